data_cache: RTL and testbench

Direct-mapped, write-through, one-word-per-line data cache that sits directly downstream of the execute-to-memory pipeline register. It replaces the flat data memory in the memory stage. It serves loads and stores from the M stage, and stalls the pipeline while a miss or store is in flight to the backing memory. Read data and stall are produced in the M stage, so `memory_to_writeback_register` consumes `ReadDataM` unchanged.

---
 rtl/riscv_mem_pkg.sv | 25 ++
 rtl/load_store_align.sv | 52 +++++
 rtl/data_cache.sv | 121 ++++++++++++
 tb/tb_data_cache.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory-stage data path:
// funct3 access codes, data-cache FSM states and byte-strobe patterns.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        AC_B  = 3'b000,
        AC_H  = 3'b001,
        AC_W  = 3'b010,
        AC_BU = 3'b100,
        AC_HU = 3'b101
    } addr_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WDONE = 2'd3
    } dcache_state_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/load_store_align.sv
// Combinational load extraction/extension and store strobe/lane replication.
// Usable in front of any word-wide data memory, cached or not.
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_wdata_o,
    output logic [3:0]  store_strb_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Sub-access address bits below the access size are ignored.
    assign ld_byte = 8'(load_word_i >> {addr_lo_i, 3'b000});
    assign ld_half = 16'(load_word_i >> {addr_lo_i[1], 4'b0000});

    always_comb begin
        load_data_o = load_word_i;
        case (ctrl_i)
            AC_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
            AC_BU:   load_data_o = {24'b0, ld_byte};
            AC_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
            AC_HU:   load_data_o = {16'b0, ld_half};
            default: load_data_o = load_word_i;
        endcase
    end

    always_comb begin
        store_strb_o  = STRB_W;
        store_wdata_o = store_data_i;
        case (ctrl_i)
            AC_B: begin
                store_strb_o  = STRB_B << addr_lo_i;
                store_wdata_o = {4{store_data_i[7:0]}};
            end
            AC_H: begin
                store_strb_o  = STRB_H << {addr_lo_i[1], 1'b0};
                store_wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                store_strb_o  = STRB_W;
                store_wdata_o = store_data_i;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate, one-word-per-line data cache
// for the M stage; stalls the pipeline while a fill or store is outstanding.
module data_cache
    import riscv_mem_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  AddressingControlM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  state_dbg
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    dcache_state_e    state_q, state_d;
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit, load_hit, fill_we, merge_we;
    logic [31:0]      ld_data, st_wdata;
    logic [3:0]       st_strb;

    assign idx       = ALUResultM[IDX_W+1:2];
    assign tag       = ALUResultM[31:IDX_W+2];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign load_hit  = MemReadM && !MemWriteM && hit;
    assign fill_we   = (state_q == ST_FILL) && mem_ack;
    assign merge_we  = (state_q == ST_WRITE) && mem_ack && hit;
    assign ReadDataM = load_hit ? ld_data : 32'b0;
    assign state_dbg = state_q;

    load_store_align u_align (
        .ctrl_i        (AddressingControlM),
        .addr_lo_i     (ALUResultM[1:0]),
        .load_word_i   (data_mem[idx]),
        .store_data_i  (WriteDataM),
        .load_data_o   (ld_data),
        .store_wdata_o (st_wdata),
        .store_strb_o  (st_strb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_we) valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid flops alone gate hits.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
        end else if (merge_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_strb[b]) data_mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        StallM    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        mem_wstrb = STRB_NONE;
        case (state_q)
            ST_IDLE: begin
                // rst gates the stall so a request held during reset does not freeze the pipe.
                if (rst && MemWriteM) begin
                    StallM  = 1'b1;
                    state_d = ST_WRITE;
                end else if (rst && MemReadM && !hit) begin
                    StallM  = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                StallM   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {ALUResultM[31:2], 2'b00};
                if (mem_ack) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                StallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {ALUResultM[31:2], 2'b00};
                mem_wdata = st_wdata;
                mem_wstrb = st_strb;
                if (mem_ack) state_d = ST_WDONE;
            end
            ST_WDONE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: vector table plus hand sequences,
// with a load-result scoreboard and a latency-programmable backing memory.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  AddressingControlM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int late_ack_cnt = 0;
    int late_served = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_model [logic [31:0]];

    typedef struct {
        logic        st;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic [3:0]  exp_strb;
        logic [31:0] exp_mw;
    } vec_t;

    vec_t vecs[18];

    data_cache #(.SETS(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .MemReadM           (MemReadM),
        .MemWriteM          (MemWriteM),
        .AddressingControlM (AddressingControlM),
        .ALUResultM         (ALUResultM),
        .WriteDataM         (WriteDataM),
        .ReadDataM          (ReadDataM),
        .StallM             (StallM),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wstrb          (mem_wstrb),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .state_dbg          (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", name, id, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] c, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (c)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // ---------------- backing memory responder ----------------
    initial begin
        logic [31:0] a, w;
        int cnt;
        mem_ack = 1'b0;
        mem_rdata = 32'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (late_ack_cnt != late_served) begin
                late_served++;
                mem_rdata = 32'h0BAD_0BAD;
                mem_ack = 1'b1;
            end else if (mem_req && lat > 0) begin
                cnt++;
                if (cnt >= lat) begin
                    a = mem_addr;
                    w = mem_model.exists(a) ? mem_model[a] : 32'b0;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_model[a] = w;
                    end else begin
                        mem_rdata = w;
                    end
                    mem_ack = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic access(input logic st, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input int latency, input logic [31:0] exp_rd,
                          input int exp_stall, input logic [3:0] exp_strb, input logic [31:0] exp_mw,
                          input int id);
        int stalls;
        int done;
        logic [3:0]  seen_strb;
        logic [31:0] seen_wd;
        lat = latency;
        MemReadM = !st;
        MemWriteM = st;
        AddressingControlM = ctrl;
        ALUResultM = addr;
        WriteDataM = wdata;
        if (!st) exp_q.push_back(exp_rd);
        stalls = 0;
        done = 0;
        seen_strb = 4'b0;
        seen_wd = 32'b0;
        for (int c = 0; c < 64 && done == 0; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                seen_strb = mem_wstrb;
                seen_wd = mem_wdata;
            end
            if (StallM) stalls++;
            else done = 1;
        end
        check("retire", id, done, 1);
        check("release_state", id, {30'b0, state_dbg}, st ? 32'd3 : 32'd0);
        if (!st) check("ReadDataM", id, ReadDataM, exp_q.pop_front());
        check("stall_cycles", id, stalls, exp_stall);
        if (st) begin
            check("mem_wstrb", id, {28'b0, seen_strb}, {28'b0, exp_strb});
            check("mem_wdata", id, seen_wd, exp_mw);
        end
        @(posedge clk);
        #1;
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
    endtask

    // ---------------- main test ----------------
    initial begin
        int id;
        int seen;
        vecs[0]  = '{1'b0, 3'b010, 32'h40, 32'h0,         1, 32'h8765_4321, 2, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 3'b010, 32'h40, 32'h0,         1, 32'h8765_4321, 0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 3'b000, 32'h43, 32'h0,         1, 32'hFFFF_FF87, 0, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'b100, 32'h43, 32'h0,         1, 32'h0000_0087, 0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h42, 32'h0,         1, 32'hFFFF_8765, 0, 4'h0, 32'h0};
        vecs[5]  = '{1'b0, 3'b101, 32'h40, 32'h0,         1, 32'h0000_4321, 0, 4'h0, 32'h0};
        vecs[6]  = '{1'b1, 3'b000, 32'h41, 32'h1234_56AB, 1, 32'h0,         2, 4'b0010, 32'hABAB_ABAB};
        vecs[7]  = '{1'b0, 3'b010, 32'h40, 32'h0,         1, 32'h8765_AB21, 0, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h80, 32'hDEAD_BEEF, 3, 32'h0,         4, 4'b1111, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 3'b010, 32'h80, 32'h0,         1, 32'hDEAD_BEEF, 2, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h40, 32'h0,         2, 32'h8765_AB21, 3, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 3'b001, 32'h42, 32'h9999_CAFE, 1, 32'h0,         2, 4'b1100, 32'hCAFE_CAFE};
        vecs[12] = '{1'b0, 3'b001, 32'h42, 32'h0,         1, 32'hFFFF_CAFE, 0, 4'h0, 32'h0};
        vecs[13] = '{1'b0, 3'b010, 32'h44, 32'h0,         1, 32'h0000_007F, 2, 4'h0, 32'h0};
        vecs[14] = '{1'b0, 3'b000, 32'h44, 32'h0,         1, 32'h0000_007F, 0, 4'h0, 32'h0};
        vecs[15] = '{1'b0, 3'b011, 32'h46, 32'h0,         1, 32'h0000_007F, 0, 4'h0, 32'h0};
        vecs[16] = '{1'b0, 3'b000, 32'h41, 32'h0,         1, 32'hFFFF_FFAB, 0, 4'h0, 32'h0};
        vecs[17] = '{1'b0, 3'b101, 32'h43, 32'h0,         1, 32'h0000_CAFE, 0, 4'h0, 32'h0};

        mem_model[32'h40] = 32'h8765_4321;
        mem_model[32'h44] = 32'h0000_007F;
        mem_model[32'h80] = 32'h1122_3344;
        mem_model[32'hC0] = 32'h5555_AAAA;

        // Reset with a load presented: everything must read as idle.
        rst = 1'b0;
        MemReadM = 1'b1;
        MemWriteM = 1'b0;
        AddressingControlM = 3'b010;
        ALUResultM = 32'h40;
        WriteDataM = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_StallM",    0, {31'b0, StallM}, 32'd0);
        check("rst_ReadDataM", 0, ReadDataM, 32'd0);
        check("rst_mem_req",   0, {31'b0, mem_req}, 32'd0);
        check("rst_mem_we",    0, {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr",  0, mem_addr, 32'd0);
        check("rst_mem_wdata", 0, mem_wdata, 32'd0);
        check("rst_mem_wstrb", 0, {28'b0, mem_wstrb}, 32'd0);
        check("rst_state",     0, {30'b0, state_dbg}, 32'd0);
        MemReadM = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++)
            access(vecs[i].st, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                   vecs[i].exp_rd, vecs[i].exp_stall, vecs[i].exp_strb, vecs[i].exp_mw, i);

        // Random-width hit loads on the cached line at 0x40.
        for (int i = 0; i < 20; i++) begin
            logic [2:0] c;
            logic [1:0] lo;
            c = 3'($urandom_range(0, 7));
            lo = 2'($urandom_range(0, 3));
            access(1'b0, c, {30'h10, lo}, 32'h0, 1, ref_load(mem_model[32'h40], c, lo), 0,
                   4'h0, 32'h0, 100 + i);
        end

        // Reset in the middle of a fill that the memory never acknowledges.
        lat = 0;
        MemReadM = 1'b1;
        MemWriteM = 1'b0;
        AddressingControlM = 3'b010;
        ALUResultM = 32'hC0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        check("fill_req_seen", 200, seen, 1);
        #2;
        rst = 1'b0;
        #1;
        check("midfill_mem_req", 200, {31'b0, mem_req}, 32'd0);
        check("midfill_StallM",  200, {31'b0, StallM}, 32'd0);
        check("midfill_addr",    200, mem_addr, 32'd0);
        MemReadM = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midfill_state", 200, {30'b0, state_dbg}, 32'd0);
        rst = 1'b1;
        late_ack_cnt++;
        repeat (3) @(negedge clk);
        check("late_ack_state", 201, {30'b0, state_dbg}, 32'd0);
        check("late_ack_req",   201, {31'b0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        id = 300;
        access(1'b0, 3'b010, 32'h40, 32'h0, 1, 32'hCAFE_AB21, 2, 4'h0, 32'h0, id);
        access(1'b0, 3'b010, 32'h44, 32'h0, 1, 32'h0000_007F, 2, 4'h0, 32'h0, id + 1);
        access(1'b0, 3'b010, 32'hC0, 32'h0, 1, 32'h5555_AAAA, 2, 4'h0, 32'h0, id + 2);

        check("exp_q_empty", 400, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
